// File: rtl/word_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module     : word_serializer_pkg
// Description: Shared definitions for the word serializer: FSM state
//              encoding and helpers that derive the first/last select
//              index from the word width and the emission order.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package word_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Index of the first bit presented for a freshly loaded word.
  function automatic int start_index(input int width, input bit msb_first);
    return msb_first ? (width - 1) : 0;
  endfunction

  // Index of the final bit of a word; presenting it raises out_last.
  function automatic int end_index(input int width, input bit msb_first);
    return msb_first ? 0 : (width - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_serializer_if.sv
`default_nettype none
// ============================================================================
// Module     : word_serializer_if
// Description: Bundles the upstream word handshake and the downstream bit
//              handshake of the word serializer.
// Ports      : in_valid/in_ready/in_data  - parallel word, upstream side
//              out_valid/out_ready        - bit beat handshake, downstream
//              out_bit/out_last/sel       - presented bit, end flag, index
//              modport master : traffic source/sink (drives in_*, out_ready)
//              modport slave  : the serializer itself
// Revision   : 1.0 - initial release
// ============================================================================
interface word_serializer_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic             out_bit;
  logic             out_last;
  logic [SEL_W-1:0] sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_last, sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_last, sel
  );
endinterface
`default_nettype wire

// File: rtl/word_serializer_sel_counter.sv
`default_nettype none
// ============================================================================
// Module     : word_serializer_sel_counter
// Description: Select index counter. Loads to START, steps one position per
//              enable (up, or down when DOWN=1), flags when sitting at STOP.
// Ports      : clk, rst - clock, synchronous active-high reset (-> START)
//              load     - reload START (wins over en)
//              en       - step one position
//              sel      - current index
//              at_end   - sel equals STOP
// Revision   : 1.0 - initial release
// ============================================================================
module word_serializer_sel_counter #(
  parameter int             SEL_W = 2,
  parameter logic [SEL_W-1:0] START = '0,
  parameter logic [SEL_W-1:0] STOP  = '1,
  parameter bit             DOWN  = 1'b0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             en,
  output logic      [SEL_W-1:0] sel,
  output logic                  at_end
);

  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

  logic [SEL_W-1:0] sel_step;

  generate
    if (DOWN) begin : g_down
      assign sel_step = sel - ONE;
    end else begin : g_up
      assign sel_step = sel + ONE;
    end
  endgenerate

  // The controller never enables a step while at_end is set, so sel stays
  // inside [START, STOP] and only wraps through a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= START;
    end else if (load) begin
      sel <= START;
    end else if (en) begin
      sel <= sel_step;
    end
  end

  assign at_end = (sel == STOP);

endmodule
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module     : word_serializer
// Description: Parallel-in / serial-out stage. Latches a WIDTH-bit word and
//              presents one bit per accepted beat, along with the select
//              index so it can also sequence an external bit selector.
//              Zero-bubble between words when upstream keeps in_valid high.
// Ports      : clk      - clock
//              rst      - synchronous active-high reset
//              bus      - word_serializer_if.slave (word in, bit out)
// Revision   : 1.0 - initial release
// ============================================================================
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SEL_W     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  word_serializer_if.slave bus
);

  localparam logic [SEL_W-1:0] START_IDX = SEL_W'(start_index(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(end_index(WIDTH, MSB_FIRST));

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] word_q;
  logic [SEL_W-1:0] sel_idx;
  logic             at_end;
  logic             in_ready;
  logic             out_valid;
  logic             out_last;
  logic             cnt_en;
  logic             accept;

  word_serializer_sel_counter #(
    .SEL_W (SEL_W),
    .START (START_IDX),
    .STOP  (END_IDX),
    .DOWN  (MSB_FIRST)
  ) u_sel_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .en     (cnt_en),
    .sel    (sel_idx),
    .at_end (at_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Final beat taken: reload back-to-back if a word is waiting.
        if (bus.out_ready && at_end) begin
          state_next = bus.in_valid ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic. Everything is forced quiet while rst is high so nothing
  // (in particular no out_last) can be handshaken during a reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    cnt_en    = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          in_ready = 1'b1;
        end
        ST_SHIFT: begin
          out_valid = 1'b1;
          out_last  = at_end;
          in_ready  = at_end & bus.out_ready;
          cnt_en    = bus.out_ready & ~at_end;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (accept) begin
      word_q <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_bit   = out_valid & word_q[sel_idx];
  assign bus.sel       = sel_idx;

endmodule
`default_nettype wire
